// File: rtl/alu_slice.sv
// One bit slice of a ripple ALU: full adder, bitwise ops, one column of a
// four-stage barrel shifter, and a registered result.
module alu_slice (
    input  logic Clock,
    input  logic Reset,
    input  logic A,
    input  logic B,
    input  logic SUB,
    input  logic ZeroA,
    input  logic CIn_Slice,
    input  logic nZ_prev,
    input  logic FAOut,
    input  logic AND,
    input  logic OR,
    input  logic XOR,
    input  logic NOT,
    input  logic NAND,
    input  logic NOR,
    input  logic ShOut,
    input  logic Sh8,
    input  logic Sh4,
    input  logic Sh2,
    input  logic Sh1,
    input  logic ShB,
    input  logic ShL,
    input  logic ShR,
    input  logic Sh8E_L,
    input  logic Sh4D_L,
    input  logic Sh2C_L,
    input  logic Sh1_L_In,
    input  logic Sh8D_R,
    input  logic Sh4C_R,
    input  logic Sh2B_R,
    input  logic Sh1_R_In,
    output logic Sh8A_L,
    output logic Sh4A_L,
    output logic Sh2A_L,
    output logic Sh1_L_Out,
    output logic Sh8Z_R,
    output logic Sh4Z_R,
    output logic Sh2Z_R,
    output logic Sh1_R_Out,
    output logic Sum,
    output logic COut,
    output logic nZ,
    output logic ALU_Out
);

    logic fa_1;
    logic fa_2;
    logic operand;
    logic shift_en;
    logic n8, n4, n2, n1;
    logic s8, s4, s2, s1;
    logic result;
    logic alu_out_q;

    // Adder
    assign fa_1 = A & ~ZeroA;
    assign fa_2 = B ^ SUB;
    assign Sum  = fa_1 ^ fa_2 ^ CIn_Slice;
    assign COut = (fa_1 & fa_2) | (CIn_Slice & (fa_1 ^ fa_2));
    assign nZ   = nZ_prev | Sum;

    // Shifter column; left chain wins when both directions are requested
    assign operand  = ShB ? B : A;
    assign shift_en = ShL | ShR;

    always_comb begin
        n8 = 1'b0;
        n4 = 1'b0;
        n2 = 1'b0;
        n1 = 1'b0;
        if (ShL) begin
            n8 = Sh8E_L;
            n4 = Sh4D_L;
            n2 = Sh2C_L;
            n1 = Sh1_L_In;
        end else if (ShR) begin
            n8 = Sh8D_R;
            n4 = Sh4C_R;
            n2 = Sh2B_R;
            n1 = Sh1_R_In;
        end
    end

    assign s8 = (shift_en & Sh8) ? n8 : operand;
    assign s4 = (shift_en & Sh4) ? n4 : s8;
    assign s2 = (shift_en & Sh2) ? n2 : s4;
    assign s1 = (shift_en & Sh1) ? n1 : s2;

    assign Sh8A_L    = operand;
    assign Sh4A_L    = s8;
    assign Sh2A_L    = s4;
    assign Sh1_L_Out = s2;
    assign Sh8Z_R    = operand;
    assign Sh4Z_R    = s8;
    assign Sh2Z_R    = s4;
    assign Sh1_R_Out = s2;

    // Result select: first active strobe wins
    always_comb begin
        result = 1'b0;
        if (FAOut) begin
            result = Sum;
        end else if (AND) begin
            result = A & B;
        end else if (OR) begin
            result = A | B;
        end else if (XOR) begin
            result = A ^ B;
        end else if (NOT) begin
            result = ~A;
        end else if (NAND) begin
            result = ~(A & B);
        end else if (NOR) begin
            result = ~(A | B);
        end else if (ShOut) begin
            result = s1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            alu_out_q <= 1'b0;
        end else begin
            alu_out_q <= result;
        end
    end

    assign ALU_Out = alu_out_q;

endmodule

// File: tb/tb_alu_slice.sv
// Randomized bench for alu_slice: a behavioural model predicts the
// combinational outputs and the registered result for every vector.
module tb_alu_slice;

    typedef struct packed {
        logic Reset;
        logic A, B, SUB, ZeroA, CIn_Slice, nZ_prev;
        logic FAOut, AND, OR, XOR, NOT, NAND, NOR, ShOut;
        logic Sh8, Sh4, Sh2, Sh1;
        logic ShB, ShL, ShR;
        logic Sh8E_L, Sh4D_L, Sh2C_L, Sh1_L_In;
        logic Sh8D_R, Sh4C_R, Sh2B_R, Sh1_R_In;
    } vec_t;

    vec_t v;
    logic Clock = 1'b0;
    logic Sh8A_L, Sh4A_L, Sh2A_L, Sh1_L_Out;
    logic Sh8Z_R, Sh4Z_R, Sh2Z_R, Sh1_R_Out;
    logic Sum, COut, nZ, ALU_Out;

    int n_vectors = 0;
    int n_miscompares = 0;

    always #5 Clock = ~Clock;

    alu_slice dut (
        .Clock(Clock), .Reset(v.Reset), .A(v.A), .B(v.B), .SUB(v.SUB), .ZeroA(v.ZeroA),
        .CIn_Slice(v.CIn_Slice), .nZ_prev(v.nZ_prev), .FAOut(v.FAOut), .AND(v.AND),
        .OR(v.OR), .XOR(v.XOR), .NOT(v.NOT), .NAND(v.NAND), .NOR(v.NOR),
        .ShOut(v.ShOut), .Sh8(v.Sh8), .Sh4(v.Sh4), .Sh2(v.Sh2), .Sh1(v.Sh1),
        .ShB(v.ShB), .ShL(v.ShL), .ShR(v.ShR), .Sh8E_L(v.Sh8E_L), .Sh4D_L(v.Sh4D_L),
        .Sh2C_L(v.Sh2C_L), .Sh1_L_In(v.Sh1_L_In), .Sh8D_R(v.Sh8D_R), .Sh4C_R(v.Sh4C_R),
        .Sh2B_R(v.Sh2B_R), .Sh1_R_In(v.Sh1_R_In), .Sh8A_L(Sh8A_L), .Sh4A_L(Sh4A_L),
        .Sh2A_L(Sh2A_L), .Sh1_L_Out(Sh1_L_Out), .Sh8Z_R(Sh8Z_R), .Sh4Z_R(Sh4Z_R),
        .Sh2Z_R(Sh2Z_R), .Sh1_R_Out(Sh1_R_Out), .Sum(Sum), .COut(COut), .nZ(nZ),
        .ALU_Out(ALU_Out)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {Sum, COut, nZ, 8 chain outputs (left then right), R}
    function automatic logic [11:0] model(input vec_t x);
        int   total;
        logic op;
        logic nb[4];
        logic en[4];
        logic st[4];
        logic cur;
        logic sum_b, cout_b, r;
        logic sel[8];
        logic val[8];
        total  = int'(x.A && !x.ZeroA) + int'(x.B != x.SUB) + int'(x.CIn_Slice);
        sum_b  = (total % 2) == 1;
        cout_b = total >= 2;
        op = x.ShB ? x.B : x.A;
        en = '{x.Sh8, x.Sh4, x.Sh2, x.Sh1};
        if (x.ShL)      nb = '{x.Sh8E_L, x.Sh4D_L, x.Sh2C_L, x.Sh1_L_In};
        else            nb = '{x.Sh8D_R, x.Sh4C_R, x.Sh2B_R, x.Sh1_R_In};
        cur = op;
        for (int i = 0; i < 4; i++) begin
            if ((x.ShL || x.ShR) && en[i]) cur = nb[i];
            st[i] = cur;
        end
        sel = '{x.FAOut, x.AND, x.OR, x.XOR, x.NOT, x.NAND, x.NOR, x.ShOut};
        val = '{sum_b, x.A && x.B, x.A || x.B, x.A != x.B, !x.A, !(x.A && x.B),
                !(x.A || x.B), st[3]};
        r = 1'b0;
        for (int i = 7; i >= 0; i--) if (sel[i]) r = val[i];
        return {sum_b, cout_b, x.nZ_prev | sum_b, op, st[0], st[1], st[2],
                op, st[0], st[1], st[2], r};
    endfunction

    task automatic apply(input string tag, input vec_t x);
        logic [11:0] m;
        v = x;
        m = model(x);
        #1;
        check({tag, "_comb"}, 16'({Sum, COut, nZ, Sh8A_L, Sh4A_L, Sh2A_L, Sh1_L_Out,
                                    Sh8Z_R, Sh4Z_R, Sh2Z_R, Sh1_R_Out}), 16'(m[11:1]));
        @(posedge Clock);
        #1;
        check({tag, "_reg"}, 16'(ALU_Out), 16'(x.Reset ? 1'b0 : m[0]));
    endtask

    initial begin
        vec_t x;
        logic [31:0] r32;
        logic [7:0]  st;
        int          k;

        v = '0;
        @(negedge Clock);
        x = '0; x.Reset = 1'b1; x.FAOut = 1'b1; x.A = 1'b1;
        apply("reset", x);
        check("reset_lit", 16'(ALU_Out), 16'd0);
        check("reset_nz", 16'(nZ), 16'd1);

        x = '0; x.A = 1; x.FAOut = 1;
        apply("rst_release", x);
        check("rst_release_lit", 16'(ALU_Out), 16'd1);

        x = '0; x.A = 1; x.B = 1; x.CIn_Slice = 1; x.FAOut = 1;
        apply("add111", x);
        check("add111_lit", 16'({Sum, COut, nZ, ALU_Out}), 16'b1111);

        x = '0; x.A = 1; x.B = 1; x.SUB = 1; x.ZeroA = 1; x.CIn_Slice = 1;
        apply("sub_zeroa", x);
        check("sub_zeroa_lit", 16'({Sum, COut}), 16'b10);

        x = '0; x.A = 1; x.AND = 1;
        apply("and10", x);
        check("and10_lit", 16'(ALU_Out), 16'd0);
        x = '0; x.A = 1; x.NAND = 1;
        apply("nand10", x);
        check("nand10_lit", 16'(ALU_Out), 16'd1);
        x = '0; x.NOR = 1;
        apply("nor00", x);
        check("nor00_lit", 16'(ALU_Out), 16'd1);

        x = '0; x.ShL = 1; x.Sh8 = 1; x.ShOut = 1;
        {x.Sh8E_L, x.Sh4D_L, x.Sh2C_L, x.Sh1_L_In} = 4'hF;
        {x.Sh8D_R, x.Sh4C_R, x.Sh2B_R, x.Sh1_R_In} = 4'hF;
        apply("shl8", x);
        check("shl8_lit", 16'({Sh8A_L, Sh4A_L, Sh1_L_Out, ALU_Out}), 16'b0111);

        x = '0; x.ShR = 1; x.ShB = 1; x.B = 1; x.ShOut = 1;
        apply("shr_b", x);
        check("shr_b_lit", 16'({Sh8Z_R, Sh1_R_Out, ALU_Out}), 16'b111);

        x = '0; x.A = 1; x.Sh8 = 1; x.Sh4 = 1; x.Sh2 = 1; x.Sh1 = 1; x.ShOut = 1;
        apply("noshift", x);
        check("noshift_lit", 16'(ALU_Out), 16'd1);

        // ShL beats ShR
        x = '0; x.ShL = 1; x.ShR = 1; x.Sh1 = 1; x.Sh1_L_In = 1; x.ShOut = 1;
        apply("dirprio", x);
        check("dirprio_lit", 16'(ALU_Out), 16'd1);

        for (int i = 0; i < 400; i++) begin
            r32 = $urandom;
            x = r32[29:0];
            x.Reset = ($urandom_range(0, 15) == 0);
            k = $urandom_range(0, 8);
            st = 8'($urandom) & (8'hFF << k);
            {x.ShOut, x.NOR, x.NAND, x.NOT, x.XOR, x.OR, x.AND, x.FAOut} = st;
            apply("rand", x);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
